// File: rtl/cook_controller.sv
`default_nettype none
// ============================================================================
// Module   : cook_controller
// Purpose  : Microwave cook sequencer with a BCD m:ss countdown, pause/resume
//            and an end-of-cook alarm.
// Revision : 1.0  initial release
// ============================================================================
module cook_controller #(
    parameter int TICKS_PER_SEC = 100,
    parameter int ALARM_SECS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    input  logic [3:0] load_min,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    output logic [3:0] cook_min,
    output logic [3:0] cook_tens,
    output logic [3:0] cook_units,
    output logic       mag_on,
    output logic       done_beep,
    output logic [1:0] state
);

    localparam int c_TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int c_ALARM_CYC = ALARM_SECS * TICKS_PER_SEC;
    localparam int c_ALARM_W   = (c_ALARM_CYC > 1) ? $clog2(c_ALARM_CYC) : 1;
    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [c_ALARM_W-1:0] c_ALARM_LAST = c_ALARM_W'(c_ALARM_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COOK  = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [3:0]            r_min_q, w_min_d;
    logic [3:0]            r_tens_q, w_tens_d;
    logic [3:0]            r_units_q, w_units_d;
    logic [c_TICK_W-1:0]   r_tick_q, w_tick_d;
    logic [c_ALARM_W-1:0]  r_alarm_q, w_alarm_d;
    logic                  r_armed_q, w_armed_d;
    logic                  r_beep_q, w_beep_d;

    logic [3:0] w_ld_min, w_ld_tens, w_ld_units;
    logic       w_ld_nonzero;
    logic [3:0] w_dec_min, w_dec_tens, w_dec_units;
    logic       w_dec_zero;

    assign w_ld_min     = (load_min   > 4'd9) ? 4'd9 : load_min;
    assign w_ld_tens    = (load_tens  > 4'd5) ? 4'd5 : load_tens;
    assign w_ld_units   = (load_units > 4'd9) ? 4'd9 : load_units;
    assign w_ld_nonzero = |{w_ld_min, w_ld_tens, w_ld_units};

    // One-second BCD decrement; saturates at 0:00.
    always_comb begin
        w_dec_min   = r_min_q;
        w_dec_tens  = r_tens_q;
        w_dec_units = r_units_q;
        if (r_units_q != 4'd0) begin
            w_dec_units = r_units_q - 4'd1;
        end else if ((r_tens_q != 4'd0) || (r_min_q != 4'd0)) begin
            w_dec_units = 4'd9;
            if (r_tens_q != 4'd0) begin
                w_dec_tens = r_tens_q - 4'd1;
            end else begin
                w_dec_tens = 4'd5;
                w_dec_min  = r_min_q - 4'd1;
            end
        end
    end

    assign w_dec_zero = ~|{w_dec_min, w_dec_tens, w_dec_units};

    always_comb begin
        w_state_d = r_state_q;
        w_min_d   = r_min_q;
        w_tens_d  = r_tens_q;
        w_units_d = r_units_q;
        w_tick_d  = r_tick_q;
        w_alarm_d = r_alarm_q;
        w_armed_d = r_armed_q;
        case (r_state_q)
            S_IDLE: begin
                w_min_d   = w_ld_min;
                w_tens_d  = w_ld_tens;
                w_units_d = w_ld_units;
                w_tick_d  = '0;
                w_alarm_d = '0;
                if (start && door_closed && !stop_clear && w_ld_nonzero) begin
                    w_state_d = S_COOK;
                end
            end
            S_COOK: begin
                if (stop_clear || !door_closed) begin
                    w_state_d = S_PAUSE;
                    w_armed_d = 1'b0;
                end else if (r_tick_q == c_TICK_LAST) begin
                    w_tick_d  = '0;
                    w_min_d   = w_dec_min;
                    w_tens_d  = w_dec_tens;
                    w_units_d = w_dec_units;
                    if (w_dec_zero) begin
                        w_state_d = S_DONE;
                        w_alarm_d = '0;
                    end
                end else begin
                    w_tick_d = r_tick_q + c_TICK_W'(1);
                end
            end
            S_PAUSE: begin
                // A resume needs start to have been seen low since the pause began.
                w_armed_d = r_armed_q | ~start;
                if (stop_clear) begin
                    w_state_d = S_IDLE;
                end else if (start && door_closed && r_armed_q) begin
                    w_state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (stop_clear || (r_alarm_q == c_ALARM_LAST)) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_alarm_d = r_alarm_q + c_ALARM_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
        w_beep_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_min_q   <= 4'd0;
            r_tens_q  <= 4'd0;
            r_units_q <= 4'd0;
            r_tick_q  <= '0;
            r_alarm_q <= '0;
            r_armed_q <= 1'b0;
            r_beep_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_min_q   <= w_min_d;
            r_tens_q  <= w_tens_d;
            r_units_q <= w_units_d;
            r_tick_q  <= w_tick_d;
            r_alarm_q <= w_alarm_d;
            r_armed_q <= w_armed_d;
            r_beep_q  <= w_beep_d;
        end
    end

    assign state      = r_state_q;
    assign cook_min   = r_min_q;
    assign cook_tens  = r_tens_q;
    assign cook_units = r_units_q;
    assign done_beep  = r_beep_q;
    assign mag_on     = (r_state_q == S_COOK) && door_closed;

endmodule
`default_nettype wire

// File: tb/tb_cook_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cook_controller
// Purpose  : Directed self-checking bench for cook_controller (4 ticks/s).
// Revision : 1.0  initial release
// ============================================================================
module tb_cook_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic [3:0] load_min, load_tens, load_units;
    logic [3:0] cook_min, cook_tens, cook_units;
    logic       mag_on;
    logic       done_beep;
    logic [1:0] state;
    logic [11:0] cook_t;

    int checks   = 0;
    int failures = 0;
    int beep_cnt;

    cook_controller #(
        .TICKS_PER_SEC (4),
        .ALARM_SECS    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .load_min    (load_min),
        .load_tens   (load_tens),
        .load_units  (load_units),
        .cook_min    (cook_min),
        .cook_tens   (cook_tens),
        .cook_units  (cook_units),
        .mag_on      (mag_on),
        .done_beep   (done_beep),
        .state       (state)
    );

    assign cook_t = {cook_min, cook_tens, cook_units};

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [11:0] v);
        {load_min, load_tens, load_units} = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b1; stop_clear = 1'b0; door_closed = 1'b1;
        load(12'h015);
        step(2);
        check("rst_state", state, 2'b00);
        check("rst_cook", cook_t, 12'h000);
        check("rst_mag", mag_on, 1'b0);
        check("rst_beep", done_beep, 1'b0);
        rst = 1'b0; start = 1'b0;
        step(1);
        check("post_rst_load", cook_t, 12'h015);

        // Digit clamping
        load({4'h3, 4'h7, 4'hC});
        step(1);
        check("clamp_tens_units", cook_t, 12'h359);
        load({4'hC, 4'h2, 4'h4});
        step(1);
        check("clamp_min", cook_t, 12'h924);

        // Stop beats start; zero time ignored
        load(12'h030); start = 1'b1; stop_clear = 1'b1;
        step(2);
        check("idle_stop_prio", state, 2'b00);
        stop_clear = 1'b0; load(12'h000);
        step(2);
        check("idle_zero_start", state, 2'b00);
        start = 1'b0;

        // Full 0:15 cook
        load(12'h015); start = 1'b1;
        step(1);
        check("c15_state", state, 2'b01);
        check("c15_cook", cook_t, 12'h015);
        check("c15_mag", mag_on, 1'b1);
        start = 1'b0; load(12'h959);
        step(3);
        check("c15_pre_tick", cook_t, 12'h015);
        step(1);
        check("c15_first_sec", cook_t, 12'h014);
        step(55);
        check("c15_last_state", state, 2'b01);
        check("c15_last_cook", cook_t, 12'h001);
        step(1);
        check("c15_done_state", state, 2'b11);
        check("c15_done_cook", cook_t, 12'h000);
        check("c15_done_beep", done_beep, 1'b1);
        check("c15_done_mag", mag_on, 1'b0);
        beep_cnt = 1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (done_beep) beep_cnt++;
            else break;
        end
        check("beep_cycles", beep_cnt, 12);
        check("done_to_idle", state, 2'b00);

        // 1:00 borrow across both digits, then stop -> pause -> clear
        load(12'h100); start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check("borrow_cook", cook_t, 12'h059);
        stop_clear = 1'b1;
        step(1);
        check("stop_pause_state", state, 2'b10);
        check("stop_pause_mag", mag_on, 1'b0);
        check("stop_pause_hold", cook_t, 12'h059);
        step(1);
        check("pause_clear", state, 2'b00);
        stop_clear = 1'b0;

        // Door open mid-cook at 0:42 with partial tick
        load(12'h043); start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check("door_pre", cook_t, 12'h042);
        step(2);
        door_closed = 1'b0;
        #1;
        check("door_mag_now", mag_on, 1'b0);
        check("door_state_now", state, 2'b01);
        step(1);
        check("door_pause", state, 2'b10);
        check("door_hold", cook_t, 12'h042);
        step(1);
        start = 1'b1;
        step(2);
        check("door_open_start", state, 2'b10);
        door_closed = 1'b1;
        step(1);
        check("resume_state", state, 2'b01);
        check("resume_cook", cook_t, 12'h042);
        check("resume_mag", mag_on, 1'b1);
        start = 1'b0;
        step(1);
        check("resume_partial", cook_t, 12'h042);
        step(1);
        check("resume_tick", cook_t, 12'h041);

        // Reset mid-cook at 0:20
        step(84);
        check("pre_rst_cook", cook_t, 12'h020);
        check("pre_rst_state", state, 2'b01);
        rst = 1'b1;
        step(1);
        check("midrst_state", state, 2'b00);
        check("midrst_cook", cook_t, 12'h000);
        check("midrst_mag", mag_on, 1'b0);
        check("midrst_beep", done_beep, 1'b0);
        rst = 1'b0; load(12'h030);
        step(1);
        check("midrst_reload", cook_t, 12'h030);
        check("midrst_idle", state, 2'b00);

        // Held start must not auto-resume
        start = 1'b1;
        step(1);
        check("held_cook", state, 2'b01);
        stop_clear = 1'b1;
        step(1);
        check("cook_stop_prio", state, 2'b10);
        stop_clear = 1'b0;
        step(3);
        check("held_no_resume", state, 2'b10);
        start = 1'b0;
        step(1);
        check("armed_pause", state, 2'b10);
        start = 1'b1;
        step(1);
        check("armed_resume", state, 2'b01);
        stop_clear = 1'b1;
        step(1);
        check("both_cook_pause", state, 2'b10);
        step(1);
        check("both_pause_idle", state, 2'b00);
        stop_clear = 1'b0; start = 1'b0;

        // stop_clear in DONE
        load(12'h001); start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check("short_done", state, 2'b11);
        check("short_beep", done_beep, 1'b1);
        stop_clear = 1'b1;
        step(1);
        check("done_clear", state, 2'b00);
        check("done_clear_beep", done_beep, 1'b0);
        stop_clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cook_controller.md
COOK_CONTROLLER -- requirements
Module: cook_controller

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100, clk cycles per countdown second.
REQ-002 SHALL have parameter ALARM_SECS, default 3, seconds done_beep stays asserted.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level, sampled each edge; start/resume cooking.
REQ-006 SHALL have port stop_clear  input  1  level; pause when cooking, clear otherwise.
REQ-007 SHALL have port door_closed  input  1  1 = door closed.
REQ-008 SHALL have ports load_min, load_tens, load_units  input  4 each  BCD time from the timer-input block.
REQ-009 SHALL have ports cook_min, cook_tens, cook_units  output  4 each  registered remaining time, BCD.
REQ-010 SHALL have port mag_on  output  1  magnetron enable.
REQ-011 SHALL have port done_beep  output  1  end-of-cook alarm.
REQ-012 SHALL have port state  output  2  IDLE=00, COOK=01, PAUSE=10, DONE=11.

Function
REQ-013 SHALL in IDLE copy the load digits into cook_* every cycle (1-cycle latency), clamping units >9 to 9, tens >5 to 5, minutes >9 to 9.
REQ-014 SHALL go IDLE->COOK when start=1, door_closed=1, stop_clear=0 and the clamped load value is nonzero; the tick counter SHALL clear to 0 on entry.
REQ-015 SHALL ignore start in IDLE when the time is 0:00 or the door is open.
REQ-016 SHALL in COOK increment a tick counter 0..TICKS_PER_SEC-1; at terminal count it SHALL wrap to 0 and decrement the time by one second in the same edge.
REQ-017 SHALL decrement in BCD: units 0 -> 9 with borrow from tens; tens 0 -> 5 with borrow from minutes; never below 0:00.
REQ-018 SHALL go COOK->DONE on the edge where the decrement produces 0:00.
REQ-019 SHALL go COOK->PAUSE when door_closed=0 or stop_clear=1; the tick counter and time SHALL hold.
REQ-020 SHALL give stop_clear priority over start when both are asserted in the same cycle, in every state.
REQ-021 SHALL in PAUSE go to COOK (resume, tick counter not cleared) on start=1 with door_closed=1, and go to IDLE on stop_clear=1.
REQ-022 SHALL require start to be sampled 0 at least once after entering PAUSE before it can trigger a resume, so a held start does not auto-resume.
REQ-023 SHALL assert done_beep for exactly ALARM_SECS*TICKS_PER_SEC cycles while in DONE, then go DONE->IDLE; stop_clear=1 in DONE SHALL go to IDLE on the next edge.
REQ-024 SHALL drive mag_on = (state==COOK) AND door_closed, so an open door removes power in the same cycle.
REQ-025 SHALL ignore load inputs in COOK, PAUSE and DONE; cook_* SHALL read 0:00 in DONE.
REQ-026 SHALL treat start arriving while the door is open in PAUSE as no-op.

Reset
REQ-027 SHALL on rst=1 at an edge set state=IDLE, cook_*=0, tick counter=0, alarm counter=0, done_beep=0, mag_on=0, overriding all other inputs, including mid-cook.
REQ-028 SHALL resume normal IDLE loading on the first edge after rst deasserts.

Verification
REQ-029 SHALL cover: load 0:15, door closed, start pulse -> COOK, mag_on=1, cook_* 0:14 after TICKS_PER_SEC cycles, DONE after 15 s, done_beep high 3*TICKS_PER_SEC cycles, then IDLE.
REQ-030 SHALL cover: load 1:00, start, one tick -> cook_* reads 0:59 (borrow across both digits).
REQ-031 SHALL cover: open door mid-cook at 0:42 -> mag_on=0 same cycle, PAUSE next edge, time holds; close door and pulse start -> COOK resumes from 0:42 with partial tick preserved.
REQ-032 SHALL cover: start and stop_clear both high in IDLE with 0:30 loaded -> remains IDLE; start with 0:00 loaded -> remains IDLE.
REQ-033 SHALL cover: rst=1 while cooking at 0:20 -> next edge state=00, all outputs 0.
REQ-034 SHALL cover: load_units=4'hC, load_tens=4'h7 in IDLE -> cook_units=9, cook_tens=5.
